// File: rtl/rtc_subclock.sv
// rtc_subclock: phase-accumulating sub-second clock with optional GPS discipline.
//
// A 32-bit phase counter advances by a programmable step every cycle. Changes
// in its top LGSUBCK bits produce the sub-second tick, and a carry out of the
// top bit produces the once-per-second strobe. A GPS PPS marker can realign
// the phase, and a small FSM tracks how close the free-running phase was to
// the GPS edge.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   FREE   | free-running, no GPS discipline (or lost it)
//   ACQ    | GPS seen, phase error outside the lock window
//   LOCKED | last realign landed within +/- one 2^-8 s of the local second
//
// Register map: addr 0 = STEP (writes of zero ignored), addr 1 = CTRL
// (bit 0 = sync_en; readback {err[31:24], 20'h0, state, 1'b0, sync_en}).

module rtc_subclock #(
    parameter int          LGSUBCK      = 2,
    parameter logic [31:0] DEFAULT_STEP = 32'h0000_002b,
    parameter logic        OPT_GPS      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr,
    input  logic        i_addr,
    input  logic [31:0] i_data,
    input  logic        i_gps_pps,
    output logic [31:0] o_data,
    output logic        o_sub_ck,
    output logic        o_pps,
    output logic        o_locked
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'b00,
        ST_ACQ    = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  state_bits;

    logic [31:0] ctr;
    logic [31:0] step;
    logic        sync_en;
    logic [7:0]  err_hi;
    logic [1:0]  miss;

    logic [32:0] sum;
    logic        nat_pps;
    logic        nat_sub;
    logic        realign;
    logic        in_window;
    logic        wr_step;
    logic        wr_ctrl;
    logic [31:0] ctrl_word;

    // Only the top byte of the captured phase error is ever read back, so
    // only that byte is stored.
    assign sum        = {1'b0, ctr} + {1'b0, step};
    assign nat_pps    = sum[32];
    assign nat_sub    = sum[32] || (sum[31:32-LGSUBCK] != ctr[31:32-LGSUBCK]);
    assign realign    = OPT_GPS && sync_en && i_gps_pps;
    assign in_window  = (ctr[31:24] == 8'hff) || (ctr[31:24] == 8'h00);
    assign wr_step    = i_wr && !i_addr && (i_data != 32'h0);
    assign wr_ctrl    = i_wr && i_addr;
    assign state_bits = state_q;
    assign ctrl_word  = {err_hi, 20'h0, state_bits, 1'b0, sync_en};
    assign o_locked   = (state_q == ST_LOCKED);

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state_q <= ST_FREE;
        else
            state_q <= state_d;
    end

    // FSM next state: disabling sync wins, then realign, then the watchdog.
    always_comb begin
        state_d = state_q;
        if (!OPT_GPS) begin
            state_d = ST_FREE;
        end else if (wr_ctrl && !i_data[0]) begin
            state_d = ST_FREE;
        end else if (realign) begin
            case (state_q)
                ST_FREE:   state_d = ST_ACQ;
                ST_ACQ,
                ST_LOCKED: state_d = in_window ? ST_LOCKED : ST_ACQ;
                default:   state_d = ST_FREE;
            endcase
        end else if (nat_pps && (miss != 2'd0)) begin
            // this natural second brings the miss count to two
            state_d = ST_FREE;
        end
    end

    // Phase counter; a realign restarts it one step past the GPS edge and
    // records where the local phase was.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctr    <= 32'h0;
            err_hi <= 8'h0;
        end else begin
            ctr <= realign ? step : sum[31:0];
            if (realign)
                err_hi <= ctr[31:24];
        end
    end

    // Configuration registers and the missed-GPS watchdog counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step    <= DEFAULT_STEP;
            sync_en <= 1'b0;
            miss    <= 2'd0;
        end else begin
            if (wr_step)
                step <= i_data;
            if (wr_ctrl)
                sync_en <= i_data[0];
            if (realign)
                miss <= 2'd0;
            else if (nat_pps && (miss != 2'd2))
                miss <= miss + 2'd1;
        end
    end

    // Registered strobes; a realign absorbs any natural carry in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sub_ck <= 1'b0;
            o_pps    <= 1'b0;
        end else begin
            o_sub_ck <= realign || nat_sub;
            o_pps    <= realign || nat_pps;
        end
    end

    // Registered readback mux.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_data <= 32'h0;
        else
            o_data <= i_addr ? ctrl_word : step;
    end

endmodule

// File: tb/tb_rtc_subclock.sv
// tb_rtc_subclock: randomized and directed checks of rtc_subclock against a
// phase/second-count reference model.

module tb_rtc_subclock;

    localparam int          LG  = 2;
    localparam logic [31:0] DEF = 32'h0000_002b;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wr;
    logic        i_addr;
    logic [31:0] i_data;
    logic        i_gps_pps;
    logic [31:0] o_data;
    logic        o_sub_ck;
    logic        o_pps;
    logic        o_locked;

    int errors = 0;
    int checks = 0;

    rtc_subclock #(.LGSUBCK(LG), .DEFAULT_STEP(DEF), .OPT_GPS(1'b1)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (i_wr),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_gps_pps(i_gps_pps),
        .o_data   (o_data),
        .o_sub_ck (o_sub_ck),
        .o_pps    (o_pps),
        .o_locked (o_locked)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: phase as a plain number, state as 0=FREE 1=ACQ 2=LOCKED.
    bit [31:0] m_ctr;
    bit [31:0] m_step;
    bit        m_sync;
    int        m_state;
    bit [7:0]  m_err;
    int        m_miss;
    bit        m_sub;
    bit        m_pps;
    bit [31:0] m_data;

    function automatic bit [34:0] m_expect();
        return {m_sub, m_pps, (m_state == 2), m_data};
    endfunction

    task automatic model_reset();
        m_ctr = 0; m_step = DEF; m_sync = 0; m_state = 0; m_err = 0;
        m_miss = 0; m_sub = 0; m_pps = 0; m_data = 0;
    endtask

    task automatic model_step(input bit wr, input bit addr, input bit [31:0] data, input bit gps);
        longint unsigned total;
        longint unsigned unit;
        bit realign, carry, tick;
        unit    = 64'd1 << (32 - LG);
        realign = gps && m_sync;
        total   = 64'(m_ctr) + 64'(m_step);
        carry   = total >= 64'h1_0000_0000;
        tick    = (total / unit) != (64'(m_ctr) / unit);
        m_data  = addr ? {m_err, 20'h0, 2'(m_state), 1'b0, m_sync} : m_step;
        if (realign) m_miss = 0;
        else if (carry) m_miss++;
        if (wr && addr && !data[0]) m_state = 0;
        else if (realign) begin
            if (m_state == 0) m_state = 1;
            else m_state = (m_ctr[31:24] == 8'hff || m_ctr[31:24] == 8'h00) ? 2 : 1;
        end else if (carry && m_miss >= 2) m_state = 0;
        if (realign) m_err = m_ctr[31:24];
        m_ctr = realign ? m_step : total[31:0];
        m_sub = realign || tick;
        m_pps = realign || carry;
        if (wr && !addr && data != 0) m_step = data;
        if (wr && addr) m_sync = data[0];
    endtask

    // Called at a falling edge: drive inputs, clock once, advance the model.
    task automatic cycle(input bit wr, input bit addr, input bit [31:0] data, input bit gps);
        i_wr = wr; i_addr = addr; i_data = data; i_gps_pps = gps;
        @(posedge i_clk);
        model_step(wr, addr, data, gps);
        @(negedge i_clk);
        i_wr = 1'b0; i_gps_pps = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_wr = 0; i_addr = 0; i_data = 0; i_gps_pps = 0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_sub_ck, o_pps, o_locked, o_data} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {o_sub_ck, o_pps, o_locked, o_data});
        end
        i_reset = 1'b0;
        model_reset();
        cycle(0, 0, 0, 0);
        checks++;
        if (o_data !== DEF) begin
            errors++;
            $display("FAIL reset_step got=%h exp=%h", o_data, DEF);
        end
        for (int n = 0; n < 8; n++) begin
            cycle(0, n[0], 0, 0);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL reset_run cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
        end
    endtask

    task automatic test_fast_step();
        int subs, last;
        subs = 0; last = -1;
        cycle(1, 0, 32'h4000_0000, 0);
        for (int n = 0; n < 16; n++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL fast_model cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
            if (o_sub_ck) subs++;
            if (o_pps) begin
                if (last >= 0) begin
                    checks++;
                    if (n - last != 4) begin
                        errors++;
                        $display("FAIL fast_pps_gap got=%0d exp=4", n - last);
                    end
                end
                last = n;
            end
        end
        checks++;
        if (subs != 16) begin
            errors++;
            $display("FAIL fast_sub_count got=%0d exp=16", subs);
        end
    endtask

    task automatic test_sub_ratio();
        int since, pps_n;
        bit seen;
        since = 0; pps_n = 0; seen = 0;
        cycle(1, 0, 32'h1000_0000, 0);
        for (int n = 0; n < 64; n++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL ratio_model cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
            if (o_sub_ck) since++;
            if (o_pps) begin
                pps_n++;
                if (seen) begin
                    checks++;
                    if (since != 4) begin
                        errors++;
                        $display("FAIL ratio_subs_per_pps got=%0d exp=4", since);
                    end
                end
                since = 0; seen = 1;
            end
        end
        checks++;
        if (pps_n != 4) begin
            errors++;
            $display("FAIL ratio_pps_count got=%0d exp=4", pps_n);
        end
    endtask

    task automatic test_gps_lock();
        cycle(1, 1, 32'h1, 0);
        cycle(1, 0, 32'h0100_0000, 0);
        cycle(0, 1, 0, 1);
        checks++;
        if ({o_sub_ck, o_pps, o_locked} !== 3'b110) begin
            errors++;
            $display("FAIL lock_first_gps got=%b exp=110", {o_sub_ck, o_pps, o_locked});
        end
        for (int n = 0; n < 255; n++) begin
            cycle(0, 1, 0, 0);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL lock_model cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
        end
        cycle(0, 1, 0, 1);
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_second_gps got=%b exp=1", o_locked);
        end
        cycle(0, 1, 0, 0);
        checks++;
        if (o_data !== 32'h0000_0009) begin
            errors++;
            $display("FAIL lock_ctrl_readback got=%h exp=00000009", o_data);
        end
    endtask

    task automatic test_watchdog();
        int pps_n;
        pps_n = 0;
        for (int n = 0; n < 519; n++) begin
            cycle(0, 1, 0, 0);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL wdog_model cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
            if (o_pps) pps_n++;
        end
        checks++;
        if (pps_n != 2) begin
            errors++;
            $display("FAIL wdog_pps_count got=%0d exp=2", pps_n);
        end
        checks++;
        if (o_locked !== 1'b0 || o_data[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL wdog_free got locked=%b state=%b exp locked=0 state=00", o_locked, o_data[3:2]);
        end
    endtask

    task automatic test_off_window();
        int guard;
        cycle(0, 1, 0, 1);
        repeat (255) cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL offwin_relock got=%b exp=1", o_locked);
        end
        guard = 0;
        while (m_ctr != 32'h8000_0000 && guard < 300) begin
            cycle(0, 1, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL offwin_timeout got=%0d cycles exp=<300", guard);
        end
        cycle(0, 1, 0, 1);
        checks++;
        if ({o_pps, o_locked} !== 2'b10) begin
            errors++;
            $display("FAIL offwin_gps got pps,locked=%b exp=10", {o_pps, o_locked});
        end
        cycle(0, 1, 0, 0);
        checks++;
        if (o_pps !== 1'b0 || o_data !== 32'h8000_0005) begin
            errors++;
            $display("FAIL offwin_after got pps=%b data=%h exp pps=0 data=80000005", o_pps, o_data);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 32'h4000_0000, 1);
        checks++;
        if ({o_sub_ck, o_pps} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_realign got=%b exp=11", {o_sub_ck, o_pps});
        end
        cycle(0, 0, 0, 0);
        checks++;
        if ({o_sub_ck, o_pps} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_new_step got=%b exp=10", {o_sub_ck, o_pps});
        end
        cycle(1, 0, 32'h0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if (o_data !== 32'h4000_0000) begin
            errors++;
            $display("FAIL zero_step_ignored got=%h exp=40000000", o_data);
        end
        cycle(1, 1, 32'h0, 0);
        cycle(0, 1, 0, 0);
        checks++;
        if (o_locked !== 1'b0 || o_data[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL sync_off got locked=%b ctrl=%h exp locked=0 ctrl=0", o_locked, o_data[3:0]);
        end
    endtask

    task automatic test_random();
        bit wr, addr, gps;
        bit [31:0] d;
        for (int n = 0; n < 3000; n++) begin
            wr   = ($urandom_range(0, 99) < 4);
            addr = 1'($urandom_range(0, 1));
            if (addr) d = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
            else begin
                case ($urandom_range(0, 3))
                    0:       d = 32'h0;
                    1:       d = 32'h0100_0000;
                    default: d = $urandom_range(32'h0010_0000, 32'h4000_0000);
                endcase
            end
            gps = ($urandom_range(0, 63) == 0);
            cycle(wr, addr, d, gps);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 32'h1000_0000, 0);
        repeat (5) cycle(0, 1, 0, 0);
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if ({o_sub_ck, o_pps, o_locked, o_data} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h exp=0", {o_sub_ck, o_pps, o_locked, o_data});
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
        cycle(0, 0, 0, 0);
        checks++;
        if (o_data !== DEF || o_sub_ck !== 1'b0 || o_pps !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after got data=%h sub=%b pps=%b exp data=%h sub=0 pps=0", o_data, o_sub_ck, o_pps, DEF);
        end
        for (int n = 0; n < 8; n++) begin
            cycle(0, n[0], 0, 0);
            checks++;
            if ({o_sub_ck, o_pps, o_locked, o_data} !== m_expect()) begin
                errors++;
                $display("FAIL reset_mid_run cyc=%0d got=%h exp=%h", n, {o_sub_ck, o_pps, o_locked, o_data}, m_expect());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fast_step();
        test_sub_ratio();
        test_gps_lock();
        test_watchdog();
        test_off_window();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_subclock.md
RTC_SUBCLOCK -- requirements
Module: rtc_subclock

Interface
REQ-001 Parameter LGSUBCK, default 2: log2 of sub-second ticks per second; must match the downstream countdown timer.
REQ-002 Parameter DEFAULT_STEP, default 32'h0000_002b: reset value of the step register (2^32 / clock frequency, rounded).
REQ-003 Parameter OPT_GPS, default 1'b1: when 0, GPS logic is removed, the state is held at FREE and i_gps_pps is ignored.
REQ-004 i_clk  in  1  the single clock; all logic is rising-edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_wr  in  1  single-cycle register write strobe.
REQ-007 i_addr  in  1  register select: 0 = STEP, 1 = CTRL.
REQ-008 i_data  in  32  write data.
REQ-009 i_gps_pps  in  1  synchronous, single-cycle GPS second marker.
REQ-010 o_data  out  32  read mux: addr 0 = step; addr 1 = {err[31:24], 20'h0, state[1:0], 1'b0, sync_en}.
REQ-011 o_sub_ck  out  1  registered sub-second tick strobe, consumed as the timer's i_sub_ck.
REQ-012 o_pps  out  1  registered once-per-second strobe.
REQ-013 o_locked  out  1  high while state == LOCKED.

Function
REQ-014 Each cycle the 32-bit phase counter ctr SHALL be replaced by ctr + step (mod 2^32), unless a realign occurs (REQ-021).
REQ-015 o_sub_ck SHALL be 1 in the cycle after an addition carries out of bit (31-LGSUBCK), i.e. when ctr[31:32-LGSUBCK] increments or wraps; otherwise 0.
REQ-016 o_pps SHALL be 1 in the cycle after an addition carries out of bit 31, and is always coincident with an o_sub_ck pulse.
REQ-017 Each o_pps pulse SHALL be preceded by exactly 2^LGSUBCK o_sub_ck pulses, counted from the previous o_pps (the pulse coincident with that previous o_pps excluded).
REQ-018 A write to addr 0 with nonzero data SHALL load step, effective from the next addition; a write of zero SHALL be ignored.
REQ-019 A write to addr 1 SHALL load sync_en = i_data[0]; writing sync_en = 0 SHALL force state to FREE on the next cycle.
REQ-020 States: FREE (00), ACQ (01), LOCKED (10); encoding 11 is unreachable.
REQ-021 Realign: on i_gps_pps with sync_en = 1 and OPT_GPS = 1:
  - ctr <= step;
  - err <= ctr value before the update;
  - o_sub_ck and o_pps both pulse in the next cycle;
  - any natural carry pending in that same cycle is absorbed, so there is no double pulse.
REQ-022 Transitions on a realign:
  - FREE->ACQ;
  - ACQ->LOCKED if the old ctr[31:24] is 8'hff or 8'h00, else stay in ACQ;
  - LOCKED stays LOCKED under the same window test, else ->ACQ.
REQ-023 Watchdog: a 2-bit miss counter clears on every realign and increments on every internally generated o_pps; when it reaches 2, state ->FREE and ctr free-runs.
REQ-024 If i_wr and i_gps_pps occur in the same cycle, both take effect; the realign loads the old step, and the new step applies from the following cycle.
REQ-025 o_data SHALL be registered, with one cycle of latency from i_addr.

Reset
REQ-026 While i_reset is high, asynchronously:
  - ctr = 0, step = DEFAULT_STEP, sync_en = 0, state = FREE, err = 0, miss counter = 0;
  - o_sub_ck = 0, o_pps = 0, o_locked = 0, o_data = 0.
REQ-027 Reset asserted mid-second SHALL discard phase with no partial strobe; counting resumes from ctr = 0 on the first clock after release.

Verification
REQ-028 LGSUBCK=2, write step=32'h4000_0000 -> o_sub_ck high every cycle, o_pps every 4th cycle.
REQ-029 step=32'h1000_0000 -> o_sub_ck every 4 cycles, o_pps every 16 cycles, 4 sub ticks per pps.
REQ-030 sync_en=1, step=32'h0100_0000, i_gps_pps every 256 cycles:
  - first pps -> ACQ;
  - second pps -> LOCKED, o_locked=1;
  - err[31:24]=8'h00.
REQ-031 From LOCKED, withhold i_gps_pps -> after 2 internal o_pps pulses, state=FREE, o_locked=0, strobes continue.
REQ-032 i_gps_pps when ctr=32'h8000_0000 in LOCKED -> state=ACQ, err=32'h8000_0000, single o_pps next cycle.
REQ-033 Write step=0 -> step unchanged; assert i_reset mid-count -> all outputs 0 immediately, step=DEFAULT_STEP.
